// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Purpose  : Hazard and sequencing controller for a 5-stage pipeline.
//            Generates PC / IF/ID / ID/EX / EX/MEM load enables, the IF/ID
//            flush and the ID/EX bubble. Handles load-use stalls, multi-cycle
//            taken-branch flushes and whole-pipeline freezes on a busy data
//            memory. Keeps saturating stall and flush counters.
// Ports    : clock, reset_n (async, active low)
//            id_rs, id_rt, id_uses_rt         - ID-stage source operands
//            ex_rt, ex_mem_read               - EX-stage load destination
//            ex_branch_taken, mem_busy        - branch resolve / memory stall
//            pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
//            ex_mem_write, stall_active       - pipeline control
//            stall_count, flush_count         - saturating event counters
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_write,
    output logic                  stall_active,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    // Down-counter only needs to hold FLUSH_CYCLES-1.
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [1:0]      c_st_run      = 2'd0;
    localparam logic [1:0]      c_st_freeze   = 2'd1;
    localparam logic [1:0]      c_st_flush    = 2'd2;
    localparam logic [FC_W-1:0] c_flush_load  = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [FC_W-1:0] c_flush_last  = FC_W'(1);

    logic [1:0]      r_state;
    logic [FC_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    logic [1:0]      w_next_state;
    logic [FC_W-1:0] w_next_flush_cnt;
    logic            w_pc_write;
    logic            w_if_id_write;
    logic            w_if_id_flush;
    logic            w_id_ex_write;
    logic            w_id_ex_bubble;
    logic            w_ex_mem_write;
    logic            w_stall_inc;
    logic            w_flush_inc;
    logic            w_load_use;
    logic            w_multi_flush;

    // A single-cycle flush is fully covered by the branch cycle itself,
    // so the FLUSH state is only entered for longer flush windows.
    generate
        if (FLUSH_CYCLES > 1) begin : g_multi_flush
            assign w_multi_flush = 1'b1;
        end else begin : g_single_flush
            assign w_multi_flush = 1'b0;
        end
    endgenerate

    // Register 0 is hard-wired, so a load to it never creates a hazard.
    assign w_load_use = ex_mem_read && (ex_rt != '0) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        w_next_state     = r_state;
        w_next_flush_cnt = r_flush_cnt;
        w_pc_write       = 1'b1;
        w_if_id_write    = 1'b1;
        w_if_id_flush    = 1'b0;
        w_id_ex_write    = 1'b1;
        w_id_ex_bubble   = 1'b0;
        w_ex_mem_write   = 1'b1;
        w_stall_inc      = 1'b0;
        w_flush_inc      = 1'b0;

        if (mem_busy) begin
            // Freeze everything; a pending flush window simply waits.
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_write  = 1'b0;
            w_ex_mem_write = 1'b0;
            w_stall_inc    = 1'b1;
            if (r_state != c_st_flush) begin
                w_next_state = c_st_freeze;
            end
        end else if (r_state == c_st_flush) begin
            // EX holds a bubble here, so branch and load-use are ignored.
            w_if_id_flush    = 1'b1;
            w_id_ex_bubble   = 1'b1;
            w_next_flush_cnt = r_flush_cnt - c_flush_last;
            if (r_flush_cnt <= c_flush_last) begin
                w_next_state = c_st_run;
            end
        end else begin
            // RUN, or the release cycle out of FREEZE.
            w_next_state = c_st_run;
            if (ex_branch_taken) begin
                w_if_id_flush  = 1'b1;
                w_id_ex_bubble = 1'b1;
                w_flush_inc    = 1'b1;
                if (w_multi_flush) begin
                    w_next_state     = c_st_flush;
                    w_next_flush_cnt = c_flush_load;
                end
            end else if (w_load_use) begin
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_id_ex_bubble = 1'b1;
                w_stall_inc    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_st_run;
            r_flush_cnt   <= '0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            r_state     <= w_next_state;
            r_flush_cnt <= w_next_flush_cnt;
            if (w_stall_inc && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
            if (w_flush_inc && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    // Outputs are forced inactive for the whole time reset is asserted.
    assign pc_write     = reset_n & w_pc_write;
    assign if_id_write  = reset_n & w_if_id_write;
    assign if_id_flush  = reset_n & w_if_id_flush;
    assign id_ex_write  = reset_n & w_id_ex_write;
    assign id_ex_bubble = reset_n & w_id_ex_bubble;
    assign ex_mem_write = reset_n & w_ex_mem_write;
    assign stall_active = reset_n & ~w_pc_write;
    assign stall_count  = r_stall_count;
    assign flush_count  = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_controller
// Purpose  : Self-checking bench. Two controller instances share the same
//            stimulus: A (FLUSH_CYCLES=3, CNT_W=4) and B (FLUSH_CYCLES=2,
//            CNT_W=16). A behavioural model tracks remaining flush cycles
//            and saturating counts per instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0;
    logic       ex_branch_taken = 1'b0, mem_busy = 1'b0;

    logic        a_pc, a_ifid, a_fl, a_idex, a_bub, a_exmem, a_sa;
    logic [3:0]  a_sc, a_fc;
    logic        b_pc, b_ifid, b_fl, b_idex, b_bub, b_exmem, b_sa;
    logic [15:0] b_sc, b_fc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pipeline_hazard_controller #(.REG_ADDR_W(5), .FLUSH_CYCLES(3), .CNT_W(4)) u_a (
        .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(a_pc), .if_id_write(a_ifid), .if_id_flush(a_fl),
        .id_ex_write(a_idex), .id_ex_bubble(a_bub), .ex_mem_write(a_exmem),
        .stall_active(a_sa), .stall_count(a_sc), .flush_count(a_fc));

    pipeline_hazard_controller #(.REG_ADDR_W(5), .FLUSH_CYCLES(2), .CNT_W(16)) u_b (
        .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(b_pc), .if_id_write(b_ifid), .if_id_flush(b_fl),
        .id_ex_write(b_idex), .id_ex_bubble(b_bub), .ex_mem_write(b_exmem),
        .stall_active(b_sa), .stall_count(b_sc), .flush_count(b_fc));

    // Reference model state, index 0 = A, 1 = B.
    int m_rem[2];
    int m_sc[2];
    int m_fc[2];
    int m_fcyc[2] = '{3, 2};
    int m_max[2]  = '{15, 65535};

    // Control vector order: {pc, if_id_w, flush, id_ex_w, bubble, ex_mem_w, stall_active}
    localparam logic [6:0] c_v_reset  = 7'b0000000;
    localparam logic [6:0] c_v_freeze = 7'b0000001;
    localparam logic [6:0] c_v_flush  = 7'b1111110;
    localparam logic [6:0] c_v_lu     = 7'b0001111;
    localparam logic [6:0] c_v_norm   = 7'b1101010;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    function automatic logic [6:0] obs_a();
        return {a_pc, a_ifid, a_fl, a_idex, a_bub, a_exmem, a_sa};
    endfunction

    function automatic logic [6:0] obs_b();
        return {b_pc, b_ifid, b_fl, b_idex, b_bub, b_exmem, b_sa};
    endfunction

    // Called aligned at a negedge; returns aligned at the next negedge.
    task automatic apply(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic [4:0] ert, input logic mr, input logic bt,
                         input logic mb);
        logic       lu;
        logic [6:0] e;
        id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_rt = ert;
        ex_mem_read = mr; ex_branch_taken = bt; mem_busy = mb;
        #1;
        lu = mr && (ert != 5'd0) && ((ert == rs) || (uses && (ert == rt)));
        check("sc_a", {28'd0, a_sc}, m_sc[0]);
        check("fc_a", {28'd0, a_fc}, m_fc[0]);
        check("sc_b", {16'd0, b_sc}, m_sc[1]);
        check("fc_b", {16'd0, b_fc}, m_fc[1]);
        for (int k = 0; k < 2; k++) begin
            if (mb) begin
                e = c_v_freeze;
                m_sc[k] = sat_inc(m_sc[k], m_max[k]);
            end else if (m_rem[k] > 0) begin
                e = c_v_flush;
                m_rem[k]--;
            end else if (bt) begin
                e = c_v_flush;
                m_fc[k] = sat_inc(m_fc[k], m_max[k]);
                m_rem[k] = m_fcyc[k] - 1;
            end else if (lu) begin
                e = c_v_lu;
                m_sc[k] = sat_inc(m_sc[k], m_max[k]);
            end else begin
                e = c_v_norm;
            end
            if (k == 0) check("ctl_a", {25'd0, obs_a()}, {25'd0, e});
            else        check("ctl_b", {25'd0, obs_b()}, {25'd0, e});
        end
        @(negedge clock);
    endtask

    task automatic idle();
        apply(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset for one full cycle, checking the forced-inactive outputs.
    task automatic do_reset();
        reset_n = 1'b0;
        id_rs = 5'd8; ex_rt = 5'd8; ex_mem_read = 1'b1;
        ex_branch_taken = 1'b1; mem_busy = 1'b0;
        #1;
        check("rst_ctl_a", {25'd0, obs_a()}, {25'd0, c_v_reset});
        check("rst_ctl_b", {25'd0, obs_b()}, {25'd0, c_v_reset});
        check("rst_cnt_a", {24'd0, a_sc, a_fc}, 32'd0);
        check("rst_cnt_b", {b_sc, b_fc}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            m_rem[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        @(negedge clock);
        do_reset();

        // Reset in the middle of A's 3-cycle flush window.
        apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle();
        do_reset();
        idle();
        check("post_rst_pc_a", {31'd0, a_pc}, 32'd1);

        // Load-use on rs, then the two non-hazard variants.
        apply(5'd8, 5'd1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        idle();
        check("lu_count_b", {16'd0, b_sc}, 32'd1);
        apply(5'd0, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        apply(5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        apply(5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);

        // Branch flush with a second branch during the flush window.
        do_reset();
        apply(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
        apply(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
        idle();
        idle();
        check("br_count_b", {16'd0, b_fc}, 32'd1);

        // Freeze with a held load-use, then the deferred stall.
        do_reset();
        repeat (3) apply(5'd8, 5'd1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
        apply(5'd8, 5'd1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        idle();
        check("frz_count_b", {16'd0, b_sc}, 32'd4);

        // Branch held across a freeze, acted on at release.
        do_reset();
        repeat (2) apply(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1);
        apply(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
        // Freeze inside the flush window holds it.
        apply(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1);
        repeat (3) idle();
        check("frzbr_count_b", {16'd0, b_fc}, 32'd1);

        // Saturation of A's 4-bit stall counter.
        do_reset();
        repeat (20) apply(5'd8, 5'd1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        idle();
        check("sat_a", {28'd0, a_sc}, 32'd15);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                apply(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 4) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Hazard and sequencing controller for the 5-stage pipeline. It drives the write enables of the PC, IF/ID, ID/EX and EX/MEM registers. It also drives the IF/ID flush and the ID/EX bubble, which forces the WB/MEM/EX control fields to zero. It handles load-use stalls, taken-branch flushes over a configurable number of cycles, and whole-pipeline freezes while data memory is busy. It keeps saturating counters for stalls and flushes.

Parameters:
REG_ADDR_W, 5, register specifier width.
FLUSH_CYCLES, 1, number of cycles IF/ID and ID/EX are flushed after a taken branch (>=1).
CNT_W, 16, width of the stall and flush counters.

Ports:
clock  input  1  rising-edge clock; one clock domain
reset_n  input  1  asynchronous active-low reset
id_rs  input  REG_ADDR_W  rs of the instruction in ID
id_rt  input  REG_ADDR_W  rt of the instruction in ID
id_uses_rt  input  1  ID instruction reads rt as a source
ex_rt  input  REG_ADDR_W  destination rt of the instruction in EX
ex_mem_read  input  1  EX instruction is a load
ex_branch_taken  input  1  branch resolved taken in EX
mem_busy  input  1  data memory not ready; freeze the pipeline
pc_write  output  1  PC load enable
if_id_write  output  1  IF/ID load enable
if_id_flush  output  1  IF/ID loads a NOP
id_ex_write  output  1  ID/EX load enable
id_ex_bubble  output  1  ID/EX loads zero WB/MEM/EX controls
ex_mem_write  output  1  EX/MEM load enable
stall_active  output  1  equals ~pc_write while not in reset
stall_count  output  CNT_W  saturating stall-cycle count
flush_count  output  CNT_W  saturating taken-branch count

Behaviour:
- States: RUN, FREEZE, FLUSH.
- State register, flush down-counter, stall_count and flush_count are reset asynchronously to RUN/0.
- While reset_n=0: all write enables 0, if_id_flush=0, id_ex_bubble=0, stall_active=0, counts 0.
- Control outputs are combinational from state and inputs (same-cycle hazard response). All state and counter updates happen on the rising edge of clock.
- load_use = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & (ex_rt==id_rt))).
- RUN, and the FREEZE release cycle, use this priority:
  1) mem_busy=1 -> freeze: pc_write=if_id_write=id_ex_write=ex_mem_write=0, flush=0, bubble=0; next state FREEZE; stall_count+1.
  2) ex_branch_taken=1 -> pc_write=1, if_id_write=1, if_id_flush=1, id_ex_write=1, id_ex_bubble=1, ex_mem_write=1; flush_count+1. If FLUSH_CYCLES>1: next state FLUSH, counter=FLUSH_CYCLES-1. Otherwise stay in RUN.
  3) load_use=1 -> pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1, ex_mem_write=1, no flush; stall_count+1; stay in RUN.
  4) otherwise all write enables 1, flush=0, bubble=0.
- FREEZE:
  - While mem_busy=1: freeze outputs, stall_count+1 per cycle.
  - On the first cycle with mem_busy=0: evaluate the RUN priority list that cycle; next state is as given there (RUN if nothing applies).
  - ex_branch_taken during a freeze is not acted on. EX is held, so the branch is re-evaluated on the release cycle.
- FLUSH:
  - mem_busy=1 -> freeze outputs; counter holds; stay in FLUSH; stall_count+1.
  - Otherwise: if_id_flush=1, id_ex_bubble=1, all write enables 1, counter-1; when counter reaches 0, next state RUN.
  - ex_branch_taken and load_use are ignored in FLUSH, because EX holds a bubble.
- Counters saturate at all-ones and never wrap.
- A stall and a flush in the same cycle count once each, according to the rule taken.
- Asserting reset_n mid-FREEZE or mid-FLUSH returns immediately to RUN with counts 0.

Test Plan:
- Reset mid-FLUSH (FLUSH_CYCLES=3, reset_n=0 after 1 flush cycle) -> enables 0, counts 0. Release -> RUN, all enables 1, flush=0.
- ex_mem_read=1, ex_rt=8, id_rs=8 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1, stall_count=1.
  - Same with ex_rt=0 -> no stall.
  - ex_rt=id_rt=9 with id_uses_rt=0 -> no stall.
- FLUSH_CYCLES=2, ex_branch_taken pulse -> if_id_flush=1 and id_ex_bubble=1 for exactly 2 cycles, pc_write=1 throughout, flush_count=1.
  - A second ex_branch_taken during the 2nd cycle -> ignored.
- mem_busy=1 for 3 cycles with load_use held true -> 3 freeze cycles (all enables 0), then 1 load-use stall cycle, then normal. stall_count=4.
- mem_busy=1 and ex_branch_taken=1 together for 2 cycles, then mem_busy=0 with branch still taken -> 2 freeze cycles, flush on the release cycle, flush_count=1.
- CNT_W=4, 20 consecutive load-use stalls -> stall_count=15 (saturated, no wrap).
